param_multicycle_core: RTL and testbench

//  Parametrised multi-cycle successor of the 8-entry non-pipelined core.

---
 rtl/param_multicycle_core.sv | 125 ++++++++++++
 tb/tb_param_multicycle_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_multicycle_core.sv
// Parametrised two-cycle (FETCH/EXEC) core with a loadable program memory,
// register file, ALU, start/halt control and a combinational debug read port.
module param_multicycle_core #(
  parameter int unsigned DW      = 5,
  parameter int unsigned AW      = 3,
  parameter int unsigned PW      = 3,
  parameter int unsigned R0_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [3+3*AW-1:0] prog_wdata,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DW-1:0]     dbg_data,
  output logic [PW-1:0]     pc,
  output logic              busy,
  output logic              halted
);

  localparam int unsigned NREG  = 2**AW;
  localparam int unsigned NPROG = 2**PW;
  localparam int unsigned IW    = 3 + 3*AW;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_BRZ  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_SUB  = 3'd4,
    OP_LDI  = 3'd5,
    OP_NOP  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  state_e          state;
  logic [IW-1:0]   ir;
  logic [DW-1:0]   regs [NREG];
  logic [IW-1:0]   pmem [NPROG];

  op_e             op;
  logic [AW-1:0]   src1, src2, dst;
  logic [2*AW-1:0] imm;
  logic [DW-1:0]   rs1, rs2, alu_res;
  logic            wr_en;
  logic [PW-1:0]   pc_next;
  logic            ctrl_idle;

  assign dbg_data  = regs[dbg_addr];
  assign ctrl_idle = (state == S_IDLE) || (state == S_HALTED);

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && ctrl_idle)
      pmem[prog_addr] <= prog_wdata;
  end

  always_comb begin
    op      = op_e'(ir[IW-1 -: 3]);
    src1    = ir[3*AW-1 -: AW];
    src2    = ir[2*AW-1 -: AW];
    dst     = ir[AW-1:0];
    imm     = {src1, src2};
    rs1     = regs[src1];
    rs2     = regs[src2];
    alu_res = '0;
    wr_en   = 1'b0;
    pc_next = pc + PW'(1);
    case (op)
      OP_ADD:  begin alu_res = rs1 + rs2; wr_en = 1'b1; end
      OP_BRZ:  if (rs1 == '0) pc_next = PW'(rs2);
      OP_AND:  begin alu_res = rs1 & rs2; wr_en = 1'b1; end
      OP_XOR:  begin alu_res = rs1 ^ rs2; wr_en = 1'b1; end
      OP_SUB:  begin alu_res = rs1 - rs2; wr_en = 1'b1; end
      OP_LDI:  begin alu_res = DW'(imm);  wr_en = 1'b1; end
      OP_NOP:  ;
      OP_HALT: pc_next = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
      ir     <= '0;
      for (int unsigned i = 0; i < NREG; i++)
        regs[AW'(i)] <= (i == 0) ? DW'(R0_INIT) : '0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc     <= '0;
            state  <= S_FETCH;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= pmem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          pc <= pc_next;
          if (wr_en)
            regs[dst] <= alu_res;
          if (op == OP_HALT) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_multicycle_core.sv
// Directed and randomized bench for param_multicycle_core, checked against an
// instruction-level model of the program, registers and PC.
module tb_param_multicycle_core;

  localparam int DW = 5;
  localparam int AW = 3;
  localparam int PW = 3;
  localparam int IW = 3 + 3*AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          prog_we;
  logic [PW-1:0] prog_addr;
  logic [IW-1:0] prog_wdata;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [PW-1:0] pc;
  logic          busy;
  logic          halted;

  always #10 clk = ~clk;

  param_multicycle_core #(
    .DW(DW), .AW(AW), .PW(PW), .R0_INIT(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .pc(pc), .busy(busy), .halted(halted)
  );

  int checks   = 0;
  int failures = 0;
  int m_regs [8];
  int m_pmem [8];
  int m_pc;
  bit m_halted;

  function automatic int enc(input int op, input int s1, input int s2, input int d);
    return (op << 9) | (s1 << 6) | (s2 << 3) | d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_regs[0] = 1;
    m_pc      = 0;
    m_halted  = 0;
  endtask

  task automatic model_step();
    int w, op, s1, s2, d, a, b, np;
    w  = m_pmem[m_pc];
    op = (w >> 9) & 7;
    s1 = (w >> 6) & 7;
    s2 = (w >> 3) & 7;
    d  = w & 7;
    a  = m_regs[s1];
    b  = m_regs[s2];
    np = (m_pc + 1) % 8;
    case (op)
      0: m_regs[d] = (a + b) % 32;
      1: if (a == 0) np = b % 8;
      2: m_regs[d] = a & b;
      3: m_regs[d] = a ^ b;
      4: m_regs[d] = (a - b + 32) % 32;
      5: m_regs[d] = (s1 * 8 + s2) % 32;
      6: ;
      default: begin np = m_pc; m_halted = 1; end
    endcase
    m_pc = np;
  endtask

  function automatic logic [DW-1:0] peek_dummy(input int r);
    return DW'(r);
  endfunction

  task automatic read_reg(input int r, output logic [DW-1:0] v);
    dbg_addr = AW'(r);
    #1;
    v = dbg_data;
  endtask

  task automatic check_regs(input string tag);
    logic [DW-1:0] v;
    for (int r = 0; r < 8; r++) begin
      read_reg(r, v);
      chk($sformatf("%s_r%0d", tag, r), 32'(v), m_regs[r]);
    end
  endtask

  task automatic check_ctrl(input string tag);
    chk({tag, "_pc"}, 32'(pc), m_pc);
    chk({tag, "_busy"}, 32'(busy), 32'(!m_halted));
    chk({tag, "_halted"}, 32'(halted), 32'(m_halted));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load(input int addr, input int w);
    prog_we    = 1'b1;
    prog_addr  = PW'(addr);
    prog_wdata = IW'(w);
    tick();
    prog_we    = 1'b0;
    m_pmem[addr] = w;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start    = 1'b0;
    m_pc     = 0;
    m_halted = 0;
  endtask

  task automatic run_instr(input string tag);
    tick();
    tick();
    model_step();
    check_ctrl(tag);
    check_regs(tag);
  endtask

  initial begin
    logic [DW-1:0] v;
    int w0;
    rst = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; dbg_addr = '0;
    foreach (m_pmem[i]) m_pmem[i] = 0;
    tick();

    // Reset state
    do_reset();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    read_reg(0, v);
    chk("rst_r0", 32'(v), 1);
    check_regs("rst");
    tick();

    // LDI r1=#9; ADD r2=r1+r1; HALT
    load(0, enc(5, 1, 1, 1));
    load(1, enc(0, 1, 1, 2));
    load(2, enc(7, 0, 0, 0));
    go();
    for (int i = 0; i < 3; i++) run_instr("prog1");
    chk("prog1_halted", 32'(halted), 1);
    chk("prog1_pc", 32'(pc), 2);
    read_reg(2, v);
    chk("prog1_r2", 32'(v), 18);

    // Wrap-around add and subtract
    load(0, enc(5, 3, 7, 1));
    load(1, enc(5, 0, 1, 2));
    load(2, enc(0, 1, 2, 3));
    load(3, enc(4, 2, 1, 4));
    load(4, enc(7, 0, 0, 0));
    go();
    for (int i = 0; i < 5; i++) run_instr("arith");
    read_reg(3, v);
    chk("add_wrap_r3", 32'(v), 0);
    read_reg(4, v);
    chk("sub_wrap_r4", 32'(v), 2);

    // BRZ taken then not taken
    load(0, enc(5, 0, 0, 0));
    load(1, enc(5, 0, 6, 5));
    load(2, enc(1, 0, 5, 0));
    load(6, enc(7, 0, 0, 0));
    go();
    for (int i = 0; i < 3; i++) run_instr("brz_t");
    chk("brz_taken_pc", 32'(pc), 6);
    run_instr("brz_t_halt");
    load(0, enc(5, 0, 1, 0));
    load(3, enc(7, 0, 0, 0));
    go();
    for (int i = 0; i < 3; i++) run_instr("brz_n");
    chk("brz_not_taken_pc", 32'(pc), 3);
    run_instr("brz_n_halt");

    // NOP loop wraps PC; writes and start while busy are ignored
    for (int a = 0; a < 8; a++) load(a, enc(6, 0, 0, 0));
    go();
    for (int i = 0; i < 8; i++) run_instr("nop");
    prog_we = 1'b1; prog_addr = PW'(1); prog_wdata = IW'(enc(7, 0, 0, 0));
    start = 1'b1;
    run_instr("nop_we");
    prog_we = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) run_instr("nop_after");
    chk("nop_busy", 32'(busy), 1);

    // Reset in EXEC of ADD r2 aborts the writeback
    do_reset();
    load(0, enc(5, 1, 1, 1));
    load(1, enc(0, 1, 1, 2));
    load(2, enc(7, 0, 0, 0));
    go();
    run_instr("abort_ldi");
    tick();
    rst = 1'b1;
    #1;
    chk("abort_pc", 32'(pc), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_halted", 32'(halted), 0);
    read_reg(2, v);
    chk("abort_r2", 32'(v), 0);
    rst = 1'b0;
    model_reset();
    check_regs("abort");
    tick();
    go();
    for (int i = 0; i < 3; i++) run_instr("rerun");
    read_reg(2, v);
    chk("rerun_r2", 32'(v), 18);

    // Random programs; word 0 is written together with start
    for (int it = 0; it < 6; it++) begin
      for (int a = 1; a < 8; a++)
        load(a, enc($urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7)));
      w0 = enc($urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7));
      prog_we = 1'b1; prog_addr = '0; prog_wdata = IW'(w0); start = 1'b1;
      tick();
      prog_we = 1'b0; start = 1'b0;
      m_pmem[0] = w0;
      m_pc = 0;
      m_halted = 0;
      for (int n = 0; n < 16 && !m_halted; n++)
        run_instr($sformatf("rnd%0d_%0d", it, n));
      if (!m_halted) begin
        do_reset();
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
